// File: rtl/dk_sound_pkg.sv
// Shared types and helpers for the dk_* discrete sound models.
// Pure declarations: no latency, no flow control.
package dk_sound_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [14:0]        env_q15_t;

    localparam int       ATTACK_SHIFT  = 7;
    localparam int       RELEASE_SHIFT = 10;
    localparam env_q15_t ENV_MAX       = 15'h7fff;

    localparam logic signed [23:0] S16_MAX = 24'sd32767;
    localparam logic signed [23:0] S16_MIN = -24'sd32768;

    function automatic sample_t sat16(input logic signed [23:0] v);
        if (v > S16_MAX) return 16'sh7fff;
        if (v < S16_MIN) return 16'sh8000;
        return v[15:0];
    endfunction

    // Rounded phase increment for a 32-bit accumulator.
    function automatic logic [31:0] phase_inc(input int unsigned freq_hz,
                                              input int unsigned sample_rate);
        logic [63:0] num;
        num = ({32'd0, freq_hz} << 32) + {33'd0, sample_rate[31:1]};
        return 32'(num / {32'd0, sample_rate});
    endfunction

endpackage

// File: rtl/dk_walk_sound_if.sv
// Sample strobe, walk trigger and PCM output of the walk effect.
// Wires only: no latency, no backpressure.
interface dk_walk_sound_if;
    import dk_sound_pkg::*;

    logic    audio_clk_en;
    logic    walk_en;
    sample_t walk_out;

    modport master (output audio_clk_en, output walk_en, input  walk_out);
    modport slave  (input  audio_clk_en, input  walk_en, output walk_out);

endinterface

// File: rtl/dk_rc_envelope.sv
// RC-style attack/release integrator in Q0.15; env_nxt is the value taken on this strobe.
// Latency: state moves one step per stb; no backpressure, idle between strobes.
module dk_rc_envelope
    import dk_sound_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     stb,
    input  logic     gate,
    output env_q15_t env_nxt
);

    env_q15_t env;
    env_q15_t rise;
    env_q15_t fall;

    always_comb begin
        rise = (ENV_MAX - env) >> ATTACK_SHIFT;
        fall = env >> RELEASE_SHIFT;
        // Minimum one-LSB release so the tail reaches true zero instead of parking at 1023.
        if (fall == '0 && env != '0) fall = 15'd1;
        env_nxt = gate ? env + rise : env - fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   env <= '0;
        else if (stb) env <= env_nxt;
    end

endmodule

// File: rtl/dk_walk_sound.sv
// Walk effect: envelope-modulated square oscillator, DC-blocked, saturated to 16-bit PCM.
// Latency 1 strobe; no backpressure, state advances only on audio_clk_en.
module dk_walk_sound
    import dk_sound_pkg::*;
#(
    parameter int unsigned CLOCK_RATE  = 120000,
    parameter int unsigned SAMPLE_RATE = 48000
) (
    input  logic           clk,
    input  logic           I_RSTn,
    dk_walk_sound_if.slave snd
);

    if (CLOCK_RATE < 2 * SAMPLE_RATE) begin : g_rate_check
        $error("dk_walk_sound: CLOCK_RATE must be at least 2*SAMPLE_RATE");
    end

    localparam logic [31:0] INC_BASE = phase_inc(400, SAMPLE_RATE);
    localparam logic [31:0] INC_SPAN = phase_inc(800, SAMPLE_RATE);

    env_q15_t           env_nxt;
    logic [46:0]        span_prod;
    logic [31:0]        inc;
    logic [31:0]        phase;
    logic [31:0]        phase_nxt;
    logic               sq;
    logic signed [16:0] half;
    logic signed [16:0] x;
    logic signed [16:0] x_prev;
    logic signed [23:0] leak;
    logic signed [23:0] y;
    logic signed [23:0] y_prev;
    sample_t            walk_q;

    dk_rc_envelope u_env (
        .clk     (clk),
        .rst_n   (I_RSTn),
        .stb     (snd.audio_clk_en),
        .gate    (snd.walk_en),
        .env_nxt (env_nxt)
    );

    // Oscillator and mixer both use the envelope value this strobe lands on.
    always_comb begin
        span_prod = {15'd0, INC_SPAN} * {32'd0, env_nxt};
        inc       = INC_BASE + 32'(span_prod >> 15);
        phase_nxt = phase + inc;
        sq        = phase_nxt[31];
        half      = {3'b000, env_nxt[14:1]};
        x         = sq ? half : -half;
        leak      = y_prev >>> 8;
        // Positive residue below 256 would never leak away; force a one-LSB step.
        if (leak == '0 && y_prev != '0) leak = 24'sd1;
        y         = 24'(x) - 24'(x_prev) + y_prev - leak;
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            phase  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            walk_q <= '0;
        end else if (snd.audio_clk_en) begin
            phase  <= phase_nxt;
            x_prev <= x;
            y_prev <= y;
            walk_q <= sat16(y);
        end
    end

    assign snd.walk_out = walk_q;

endmodule

// File: tb/tb_dk_walk_sound.sv
// Directed bench for dk_walk_sound: reset, first samples, attack/release shape, gating, repetition.
module tb_dk_walk_sound;
    import dk_sound_pkg::*;

    logic clk = 1'b0;
    logic I_RSTn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dk_walk_sound_if snd ();

    dk_walk_sound #(.CLOCK_RATE(120000), .SAMPLE_RATE(48000)) dut (
        .clk    (clk),
        .I_RSTn (I_RSTn),
        .snd    (snd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One strobe; on return (a falling edge) walk_out holds the result of that strobe.
    task automatic strobe();
        @(negedge clk) snd.audio_clk_en = 1'b1;
        @(negedge clk) snd.audio_clk_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) I_RSTn = 1'b0;
        @(negedge clk) I_RSTn = 1'b1;
    endtask

    int prev, cur, bad, last_x, period, prev_period, n_periods, peak, peak_early;
    int golden [200];
    int cyc_peak [3];

    initial begin
        snd.audio_clk_en = 1'b0;
        snd.walk_en      = 1'b1;

        // Reset held with strobes running: silence.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            strobe();
            if (snd.walk_out !== 16'sd0) bad++;
        end
        check("reset_hold_nonzero_samples", bad, 0);
        check("reset_state", snd.walk_out, 0);

        // First strobes after release, from the zero state (E=255,509,761).
        @(negedge clk) I_RSTn = 1'b1;
        strobe(); check("first_sample", snd.walk_out, -127);
        strobe(); check("second_sample", snd.walk_out, -253);
        strobe(); check("third_sample", snd.walk_out, -378);

        // Asynchronous reset mid-sound.
        repeat (300) strobe();
        check_range("sounding_before_reset", iabs(snd.walk_out), 1000, 32767);
        #2 I_RSTn = 1'b0;
        #1 check("async_reset_silence", snd.walk_out, 0);

        // walk_en low from reset: output stays exactly zero.
        snd.walk_en = 1'b0;
        @(negedge clk) I_RSTn = 1'b1;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            strobe();
            if (snd.walk_out !== 16'sd0) bad++;
        end
        check("idle_nonzero_samples", bad, 0);

        // Attack: steady ~1200 Hz, large amplitude.
        snd.walk_en = 1'b1;
        prev = snd.walk_out; last_x = -1; period = 0; peak = 0; peak_early = 0;
        for (int i = 0; i < 6000; i++) begin
            strobe();
            cur = snd.walk_out;
            if (prev < 0 && cur >= 0) begin
                if (last_x >= 0) period = i - last_x;
                last_x = i;
            end
            if (i >= 1000 && i < 1200 && iabs(cur) > peak_early) peak_early = iabs(cur);
            if (i >= 4000 && iabs(cur) > peak) peak = iabs(cur);
            prev = cur;
        end
        check_range("attack_peak_by_1000", peak_early, 12000, 32767);
        check_range("attack_period", period, 38, 42);
        check_range("attack_peak", peak, 12000, 32767);

        // Release: period grows toward 120, then exact silence.
        snd.walk_en = 1'b0;
        last_x = -1; prev_period = 0; n_periods = 0; bad = 0; period = 0;
        for (int i = 0; i < 7500; i++) begin
            strobe();
            cur = snd.walk_out;
            if (i < 3000 && prev < 0 && cur >= 0) begin
                if (last_x >= 0) begin
                    period = i - last_x;
                    if (prev_period > 0 && period < prev_period - 1) bad++;
                    prev_period = period;
                    n_periods++;
                end
                last_x = i;
            end
            if (i == 6000) check_range("release_small_6000", iabs(cur), 0, 499);
            prev = cur;
        end
        check("release_period_shrinks", bad, 0);
        check_range("release_period_count", n_periods, 10, 100);
        check_range("release_late_period", period, 90, 120);
        check("release_settles_zero", snd.walk_out, 0);

        // Strobe gating: a long gap with walk_en toggling leaves the sequence intact.
        do_reset();
        snd.walk_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            strobe();
            golden[i] = snd.walk_out;
        end
        do_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            strobe();
            if (int'(snd.walk_out) != golden[i]) bad++;
        end
        check("gating_rerun_matches", bad, 0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk) snd.walk_en = ~snd.walk_en;
            if (int'(snd.walk_out) != golden[99]) bad++;
        end
        check("gating_hold", bad, 0);
        snd.walk_en = 1'b1;
        bad = 0;
        for (int i = 100; i < 200; i++) begin
            strobe();
            if (int'(snd.walk_out) != golden[i]) bad++;
        end
        check("gating_resume", bad, 0);

        // Repeated on/off cycles: no wrap, steady peak repeats.
        do_reset();
        bad = 0;
        prev = snd.walk_out;
        for (int c = 0; c < 3; c++) begin
            snd.walk_en = 1'b1;
            cyc_peak[c] = 0;
            for (int i = 0; i < 2000; i++) begin
                strobe();
                cur = snd.walk_out;
                if (iabs(prev) > 30000 && iabs(cur) > 30000 && ((prev < 0) != (cur < 0))) bad++;
                if (i >= 1000 && iabs(cur) > cyc_peak[c]) cyc_peak[c] = iabs(cur);
                prev = cur;
            end
            snd.walk_en = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                strobe();
                cur = snd.walk_out;
                if (iabs(prev) > 30000 && iabs(cur) > 30000 && ((prev < 0) != (cur < 0))) bad++;
                prev = cur;
            end
        end
        check("cycles_no_wrap", bad, 0);
        check_range("cycle2_peak", cyc_peak[1], 12000, 32767);
        check_range("cycle3_vs_cycle2_peak", cyc_peak[2] - cyc_peak[1], -64, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
